// File: rtl/param_stream_loader.sv
// Parameter frame loader: receives header + 24 payload bytes + checksum into a shadow
// buffer, then commits the verified set to the parameter bank one byte per cycle.
module param_stream_loader (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       abort,
   output logic       param_we,
   output logic [4:0] param_addr,
   output logic [7:0] param_data,
   output logic       params_valid,
   output logic       load_done,
   output logic       load_error,
   output logic       busy
);

   localparam int unsigned N_PARAMS = 24;
   localparam int unsigned IDX_W    = 5;
   localparam int unsigned DATA_W   = 8;
   localparam logic [DATA_W-1:0] HEADER   = 8'hA5;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_PARAMS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PAYLOAD,
      S_CHECK,
      S_COMMIT,
      S_ERR
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [IDX_W-1:0]  idx;
   logic [DATA_W-1:0] sum;
   logic [DATA_W-1:0] shadow [N_PARAMS];
   logic              xfer;

   assign xfer = in_valid & in_ready;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:    if (xfer && in_data == HEADER) state_next = S_PAYLOAD;
         S_PAYLOAD: begin
            if (abort)                         state_next = S_IDLE;
            else if (xfer && idx == LAST_IDX)  state_next = S_CHECK;
         end
         S_CHECK: begin
            if (abort)     state_next = S_IDLE;
            else if (xfer) state_next = (in_data == sum) ? S_COMMIT : S_ERR;
         end
         S_COMMIT:  if (idx == LAST_IDX) state_next = S_IDLE;
         S_ERR:     state_next = S_IDLE;
         default:   state_next = S_IDLE;
      endcase
   end

   // Output decode; abort withdraws ready so an aborting edge never consumes a byte
   always_comb begin
      in_ready   = 1'b0;
      param_we   = 1'b0;
      param_addr = '0;
      param_data = '0;
      load_error = 1'b0;
      busy       = (state != S_IDLE);
      case (state)
         S_IDLE:    in_ready = 1'b1;
         S_PAYLOAD,
         S_CHECK:   in_ready = ~abort;
         S_COMMIT: begin
            param_we   = 1'b1;
            param_addr = idx;
            param_data = shadow[idx];
         end
         S_ERR:     load_error = 1'b1;
         default:   ;
      endcase
   end

   // Index, running checksum and completion status
   always_ff @(posedge clk) begin
      if (reset) begin
         idx          <= '0;
         sum          <= '0;
         params_valid <= 1'b0;
         load_done    <= 1'b0;
      end else begin
         load_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (xfer && in_data == HEADER) begin
                  idx <= '0;
                  sum <= '0;
               end
            end
            S_PAYLOAD: begin
               if (xfer) begin
                  sum <= sum + in_data;
                  idx <= idx + IDX_W'(1);
               end
            end
            S_CHECK: begin
               if (xfer && in_data == sum) begin
                  params_valid <= 1'b0;
                  idx          <= '0;
               end
            end
            S_COMMIT: begin
               idx <= idx + IDX_W'(1);
               if (idx == LAST_IDX) begin
                  params_valid <= 1'b1;
                  load_done    <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Shadow buffer needs no reset; it is always refilled before a commit
   always_ff @(posedge clk) begin
      if (state == S_PAYLOAD && xfer) shadow[idx] <= in_data;
   end

endmodule

// File: tb/tb_param_stream_loader.sv
// Randomised scoreboard bench for param_stream_loader: stimulus pushes expected bank
// writes and completion events, a negedge monitor pops and compares them.
module tb_param_stream_loader;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       abort;
   logic       param_we;
   logic [4:0] param_addr;
   logic [7:0] param_data;
   logic       params_valid;
   logic       load_done;
   logic       load_error;
   logic       busy;

   param_stream_loader dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .abort(abort), .param_we(param_we),
      .param_addr(param_addr), .param_data(param_data),
      .params_valid(params_valid), .load_done(load_done),
      .load_error(load_error), .busy(busy)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int we_cycles = 0;
   bit mon_en = 1'b0;
   bit exp_pv = 1'b0;

   logic [12:0] wq [$];   // {addr, data}
   logic [1:0]  evq [$];  // {is_done, expected params_valid}

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Monitor: every cycle compare DUT outputs against the scoreboard
   always @(negedge clk) begin
      if (mon_en) begin
         if (param_we) begin
            we_cycles++;
            chk("ready_low_in_commit", 32'(in_ready), 32'd0);
            chk("busy_in_commit", 32'(busy), 32'd1);
            if (wq.size() == 0) chk("unexpected_write", {19'd0, param_addr, param_data}, 32'h1FFF_FFFF);
            else chk("write_addr_data", {19'd0, param_addr, param_data}, {19'd0, wq.pop_front()});
         end else begin
            chk("idle_addr_data", {19'd0, param_addr, param_data}, 32'd0);
         end
         if (load_done) begin
            if (evq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else begin
               logic [1:0] ev;
               ev = evq.pop_front();
               chk("done_kind", 32'(ev[1]), 32'd1);
               chk("valid_at_done", 32'(params_valid), 32'd1);
            end
         end
         if (load_error) begin
            if (evq.size() == 0) chk("unexpected_error", 32'd1, 32'd0);
            else begin
               logic [1:0] ev;
               ev = evq.pop_front();
               chk("error_kind", 32'(ev[1]), 32'd0);
               chk("valid_at_error", 32'(params_valid), 32'(ev[0]));
            end
         end
      end
   end

   // Reference model: a frame is good iff checksum equals payload sum mod 256
   task automatic model_frame(input logic [7:0] p [$], input logic [7:0] cks, input bit full);
      int s = 0;
      foreach (p[i]) s += int'(p[i]);
      if (cks == 8'(s % 256)) begin
         for (int k = 0; k < 24; k++)
            if (full || k <= 10) wq.push_back({5'(k), p[k]});
         if (full) begin
            exp_pv = 1'b1;
            evq.push_back(2'b11);
         end else begin
            exp_pv = 1'b0;
         end
      end else begin
         evq.push_back({1'b0, exp_pv});
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      bit done = 1'b0;
      int n = 0;
      if (gaps)
         while ($urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
      in_valid = 1'b1;
      in_data  = b;
      while (!done) begin
         @(negedge clk);
         done = in_ready;
         @(posedge clk); #1;
         n++;
         if (!done && n > 200) begin
            chk("send_timeout", 32'd1, 32'd0);
            done = 1'b1;
         end
      end
   endtask

   task automatic send_frame(input logic [7:0] p [$], input logic [7:0] cks, input bit gaps, input bit hold);
      send_byte(8'hA5, gaps);
      foreach (p[i]) send_byte(p[i], gaps);
      send_byte(cks, gaps);
      if (hold) begin
         in_data = 8'h00;
         repeat (30) begin @(posedge clk); #1; end
      end
      in_valid = 1'b0;
   endtask

   task automatic do_abort();
      in_valid = 1'b0;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      chk("idle_after_abort", 32'(busy), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic wait_drained();
      int n = 0;
      while ((wq.size() != 0 || evq.size() != 0) && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      repeat (3) begin @(posedge clk); #1; end
      chk("writes_drained", 32'(wq.size()), 32'd0);
      chk("events_drained", 32'(evq.size()), 32'd0);
      chk("params_valid_level", 32'(params_valid), 32'(exp_pv));
   endtask

   initial begin
      logic [7:0] p [$];
      logic [7:0] cks;
      int s;
      int we0;

      reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; abort = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_we_addr_data", {19'd0, param_we, param_addr, param_data}, 32'd0);
      chk("rst_flags", {28'd0, params_valid, load_done, load_error, busy}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0; abort = 1'b0;
      mon_en = 1'b1;

      // Good frame 01..18 with checksum 2C
      p.delete();
      for (int i = 1; i <= 24; i++) p.push_back(8'(i));
      model_frame(p, 8'h2C, 1'b1);
      send_frame(p, 8'h2C, 1'b0, 1'b0);
      wait_drained();

      // Bad checksum 2D: no writes, error, valid unchanged
      model_frame(p, 8'h2D, 1'b1);
      send_frame(p, 8'h2D, 1'b0, 1'b0);
      wait_drained();

      // Random gaps, in_valid held high through commit
      we0 = we_cycles;
      model_frame(p, 8'h2C, 1'b1);
      send_frame(p, 8'h2C, 1'b1, 1'b1);
      wait_drained();
      chk("commit_cycle_count", 32'(we_cycles - we0), 32'd24);

      // Junk bytes, partial frame, abort, then a good frame
      send_byte(8'h00, 1'b1);
      send_byte(8'h3C, 1'b1);
      send_byte(8'hA5, 1'b1);
      send_byte(8'h10, 1'b1);
      send_byte(8'h20, 1'b1);
      do_abort();
      model_frame(p, 8'h2C, 1'b1);
      send_frame(p, 8'h2C, 1'b1, 1'b0);
      wait_drained();

      // All-header payload, checksum wraps to 78
      p.delete();
      for (int i = 0; i < 24; i++) p.push_back(8'hA5);
      model_frame(p, 8'h78, 1'b1);
      send_frame(p, 8'h78, 1'b1, 1'b0);
      wait_drained();

      // Random frames: good, bad, or aborted mid-frame
      for (int f = 0; f < 8; f++) begin
         int ab;
         p.delete();
         s = 0;
         for (int i = 0; i < 24; i++) begin
            p.push_back(8'($urandom));
            s += int'(p[i]);
         end
         cks = 8'(s % 256);
         if ($urandom_range(0, 2) == 0) cks = cks + 8'($urandom_range(1, 255));
         ab = $urandom_range(0, 3) == 0 ? $urandom_range(0, 24) : -1;
         if (ab >= 0) begin
            send_byte(8'hA5, 1'b1);
            for (int i = 0; i < ab; i++) send_byte(p[i], 1'b1);
            do_abort();
         end else begin
            model_frame(p, cks, 1'b1);
            send_frame(p, cks, 1'b1, 1'b0);
            wait_drained();
         end
      end

      // Reset during commit at k=10
      p.delete();
      s = 0;
      for (int i = 0; i < 24; i++) begin
         p.push_back(8'($urandom));
         s += int'(p[i]);
      end
      model_frame(p, 8'(s % 256), 1'b0);
      send_frame(p, 8'(s % 256), 1'b0, 1'b0);
      begin
         int n = 0;
         bit hit = 1'b0;
         while (!hit && n < 100) begin
            @(negedge clk);
            hit = param_we && (param_addr == 5'd10);
            n++;
         end
         chk("reached_commit_k10", 32'(hit), 32'd1);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("we_after_reset", 32'(param_we), 32'd0);
      chk("valid_after_reset", 32'(params_valid), 32'd0);
      chk("busy_after_reset", 32'(busy), 32'd0);
      wait_drained();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
